// File: rtl/bus_timer_periph_pkg.sv
// Shared definitions for the memory-mapped interval timer: bus widths,
// register offsets and CTRL/STATUS bit positions.
package bus_timer_periph_pkg;

  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned REG_WIDTH  = 8;

  localparam logic [2:0] TMR_CTRL      = 3'd0;
  localparam logic [2:0] TMR_STATUS    = 3'd1;
  localparam logic [2:0] TMR_RELOAD_LO = 3'd2;
  localparam logic [2:0] TMR_RELOAD_HI = 3'd3;
  localparam logic [2:0] TMR_COUNT_LO  = 3'd4;
  localparam logic [2:0] TMR_COUNT_HI  = 3'd5;
  localparam logic [2:0] TMR_PRESCALE  = 3'd6;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_AUTO   = 1;
  localparam int unsigned CTRL_IE     = 2;
  localparam int unsigned STATUS_FLAG = 0;
  localparam int unsigned STATUS_RUN  = 1;

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider for the interval timer: pulses tick once every div+1 clocks
// while enabled; held at zero when disabled or explicitly cleared.
module timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] div,
  output logic       tick
);

  logic [7:0] pc_q, pc_d;

  assign tick = en & (pc_q == div);

  always_comb begin
    pc_d = pc_q;
    if (clr || !en) begin
      pc_d = 8'd0;
    end else if (tick) begin
      pc_d = 8'd0;
    end else begin
      pc_d = pc_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= 8'd0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/bus_timer_periph.sv
// 16-bit interval timer responding on the CPU bus in an 8-byte window, with
// auto-reload, sticky expiry flag and an active-low level interrupt.
module bus_timer_periph
  import bus_timer_periph_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 16'h4000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [REG_WIDTH-1:0]  din,
  output logic [REG_WIDTH-1:0]  dout,
  output logic                  hit,
  output logic                  irq_n
);

  logic                 sel;
  logic [2:0]           off;
  logic                 wr_ctrl, wr_status, wr_reload_lo, wr_reload_hi, wr_prescale;
  logic                 rd_count_lo;
  logic                 tick, expire, presc_clr;

  logic                 en_q, en_d, auto_q, auto_d, ie_q, ie_d, flag_q, flag_d;
  logic [15:0]          reload_q, reload_d, count_q, count_d;
  logic [7:0]           prescale_q, prescale_d, hi_latch_q, hi_latch_d;
  logic [REG_WIDTH-1:0] rdata, dout_q, dout_d;
  logic                 hit_q, hit_d;

  assign sel = (addr[15:3] == BASE_ADDR[15:3]);
  assign off = addr[2:0];

  assign wr_ctrl      = sel & we & (off == TMR_CTRL);
  assign wr_status    = sel & we & (off == TMR_STATUS);
  assign wr_reload_lo = sel & we & (off == TMR_RELOAD_LO);
  assign wr_reload_hi = sel & we & (off == TMR_RELOAD_HI);
  assign wr_prescale  = sel & we & (off == TMR_PRESCALE);
  assign rd_count_lo  = sel & ~we & (off == TMR_COUNT_LO);

  // A RELOAD_HI write overrides any tick landing on the same edge.
  assign expire = tick & ~wr_reload_hi & (count_q == 16'd0);

  timer_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en_q),
    .clr   (presc_clr),
    .div   (prescale_q),
    .tick  (tick)
  );

  always_comb begin
    en_d       = en_q;
    auto_d     = auto_q;
    ie_d       = ie_q;
    flag_d     = flag_q;
    reload_d   = reload_q;
    count_d    = count_q;
    prescale_d = prescale_q;
    hi_latch_d = hi_latch_q;
    presc_clr  = 1'b0;

    if (tick && !wr_reload_hi) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else if (auto_q) begin
        count_d = reload_q;
      end else begin
        en_d = 1'b0;
      end
    end

    if (wr_status && din[STATUS_FLAG]) flag_d = 1'b0;
    if (expire) flag_d = 1'b1;

    if (wr_ctrl) begin
      en_d      = din[CTRL_EN];
      auto_d    = din[CTRL_AUTO];
      ie_d      = din[CTRL_IE];
      presc_clr = din[CTRL_EN] & ~en_q;
    end
    if (wr_reload_lo) reload_d[7:0] = din;
    if (wr_reload_hi) begin
      reload_d[15:8] = din;
      count_d        = {din, reload_q[7:0]};
      en_d           = 1'b1;
      presc_clr      = 1'b1;
    end
    if (wr_prescale) prescale_d = din;
    if (rd_count_lo) hi_latch_d = count_q[15:8];
  end

  // Read data always reflects pre-edge register state.
  always_comb begin
    rdata = '0;
    case (off)
      TMR_CTRL:      rdata = {5'd0, ie_q, auto_q, en_q};
      TMR_STATUS:    rdata = {6'd0, en_q, flag_q};
      TMR_RELOAD_LO: rdata = reload_q[7:0];
      TMR_RELOAD_HI: rdata = reload_q[15:8];
      TMR_COUNT_LO:  rdata = count_q[7:0];
      TMR_COUNT_HI:  rdata = hi_latch_q;
      TMR_PRESCALE:  rdata = prescale_q;
      default:       rdata = '0;
    endcase
    dout_d = sel ? rdata : '0;
    hit_d  = sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      ie_q       <= 1'b0;
      flag_q     <= 1'b0;
      reload_q   <= 16'd0;
      count_q    <= 16'd0;
      prescale_q <= 8'd0;
      hi_latch_q <= 8'd0;
      dout_q     <= '0;
      hit_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      auto_q     <= auto_d;
      ie_q       <= ie_d;
      flag_q     <= flag_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      hi_latch_q <= hi_latch_d;
      dout_q     <= dout_d;
      hit_q      <= hit_d;
    end
  end

  assign dout  = dout_q;
  assign hit   = hit_q;
  assign irq_n = ~(flag_q & ie_q);

endmodule

// File: tb/tb_bus_timer_periph.sv
// Directed bench for bus_timer_periph: register access, one-shot and
// auto-reload timing, latched reads, same-edge collisions and decode.
module tb_bus_timer_periph;

  localparam logic [15:0] BASE = 16'h4000;

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  logic        we;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        hit;
  logic        irq_n;

  int checks;
  int failures;
  logic [7:0] rd_data;
  logic       rd_hit;

  bus_timer_periph #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .hit   (hit),
    .irq_n (irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a;
    we   = 1'b1;
    din  = d;
    @(posedge clk);
    #1;
    we   = 1'b0;
    addr = 16'h0000;
    din  = 8'h00;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [7:0] d, output logic h);
    @(negedge clk);
    addr = a;
    we   = 1'b0;
    @(posedge clk);
    #1;
    d    = dout;
    h    = hit;
    addr = 16'h0000;
  endtask

  task automatic rd_chk(input logic [15:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] d;
    logic       h;
    bus_rd(a, d, h);
    check(tag, d, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    addr     = 16'h0000;
    we       = 1'b0;
    din      = 8'h00;

    // Reset held for 3 cycles while a CTRL write is attempted.
    reset = 1'b1;
    addr  = BASE;
    we    = 1'b1;
    din   = 8'h07;
    repeat (3) @(posedge clk);
    #1;
    check("reset_irq_n", 8'(irq_n), 8'h01);
    check("reset_hit", 8'(hit), 8'h00);
    check("reset_dout", dout, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    we    = 1'b0;
    addr  = 16'h0000;
    din   = 8'h00;
    for (int i = 0; i < 8; i++) begin
      rd_chk(BASE + 16'(i), 8'h00, $sformatf("reset_reg%0d", i));
    end

    // One-shot: RELOAD=3, PRESCALE=0 -> expiry 4 clocks after RELOAD_HI edge.
    bus_wr(BASE + 16'd6, 8'h00);
    bus_wr(BASE + 16'd2, 8'h03);
    bus_wr(BASE + 16'd0, 8'h04);
    bus_wr(BASE + 16'd3, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("oneshot_irq_before", 8'(irq_n), 8'h01);
    @(posedge clk);
    #1;
    check("oneshot_irq_fall", 8'(irq_n), 8'h00);
    rd_chk(BASE + 16'd1, 8'h01, "oneshot_status");
    rd_chk(BASE + 16'd0, 8'h04, "oneshot_ctrl_en_clear");
    repeat (4) @(posedge clk);
    rd_chk(BASE + 16'd4, 8'h00, "oneshot_count_lo");
    rd_chk(BASE + 16'd5, 8'h00, "oneshot_count_hi");
    bus_wr(BASE + 16'd1, 8'h01);
    check("oneshot_irq_clear", 8'(irq_n), 8'h01);
    rd_chk(BASE + 16'd1, 8'h00, "oneshot_status_clear");

    // Auto-reload: RELOAD=1, PRESCALE=2 -> expiry every 6 clocks.
    bus_wr(BASE + 16'd0, 8'h06);
    bus_wr(BASE + 16'd6, 8'h02);
    bus_wr(BASE + 16'd2, 8'h01);
    bus_wr(BASE + 16'd3, 8'h00);
    repeat (5) @(posedge clk);
    #1;
    check("auto_p1_before", 8'(irq_n), 8'h01);
    @(posedge clk);
    #1;
    check("auto_p1_fall", 8'(irq_n), 8'h00);
    for (int k = 2; k <= 3; k++) begin
      bus_wr(BASE + 16'd1, 8'h01);
      check($sformatf("auto_p%0d_clear", k), 8'(irq_n), 8'h01);
      repeat (4) @(posedge clk);
      #1;
      check($sformatf("auto_p%0d_before", k), 8'(irq_n), 8'h01);
      @(posedge clk);
      #1;
      check($sformatf("auto_p%0d_fall", k), 8'(irq_n), 8'h00);
    end
    bus_wr(BASE + 16'd0, 8'h00);
    bus_wr(BASE + 16'd1, 8'h01);
    check("auto_stop_irq", 8'(irq_n), 8'h01);

    // Latched COUNT_HI read.
    bus_wr(BASE + 16'd6, 8'h00);
    bus_wr(BASE + 16'd2, 8'h00);
    bus_wr(BASE + 16'd3, 8'h01);
    rd_chk(BASE + 16'd4, 8'h00, "latch_count_lo");
    repeat (5) @(posedge clk);
    rd_chk(BASE + 16'd5, 8'h01, "latch_count_hi");
    bus_wr(BASE + 16'd0, 8'h00);

    // STATUS clear-write landing on the expiry edge: set wins.
    bus_wr(BASE + 16'd2, 8'h03);
    bus_wr(BASE + 16'd0, 8'h04);
    bus_wr(BASE + 16'd3, 8'h00);
    repeat (3) @(posedge clk);
    bus_wr(BASE + 16'd1, 8'h01);
    check("collide_clear_irq", 8'(irq_n), 8'h00);
    rd_chk(BASE + 16'd1, 8'h01, "collide_clear_status");
    bus_wr(BASE + 16'd1, 8'h01);
    check("collide_clear_after", 8'(irq_n), 8'h01);

    // RELOAD_HI write on a tick edge: write wins, COUNT = 0x0005.
    bus_wr(BASE + 16'd6, 8'h02);
    bus_wr(BASE + 16'd2, 8'h05);
    bus_wr(BASE + 16'd3, 8'h00);
    repeat (2) @(posedge clk);
    bus_wr(BASE + 16'd3, 8'h00);
    rd_chk(BASE + 16'd4, 8'h05, "collide_reload_count");
    bus_wr(BASE + 16'd0, 8'h00);

    // Decode window and read latency.
    bus_wr(BASE + 16'd8, 8'h07);
    check("decode_out_hit", 8'(hit), 8'h00);
    rd_chk(BASE + 16'd0, 8'h00, "decode_ctrl_untouched");
    rd_chk(BASE + 16'd6, 8'h02, "prescale_readback");
    rd_chk(BASE + 16'd2, 8'h05, "reload_lo_readback");
    bus_rd(BASE + 16'd7, rd_data, rd_hit);
    check("reg7_dout", rd_data, 8'h00);
    check("reg7_hit", 8'(rd_hit), 8'h01);
    bus_rd(16'h0000, rd_data, rd_hit);
    check("miss_hit", 8'(rd_hit), 8'h00);
    check("miss_dout", rd_data, 8'h00);

    // Reset asserted mid-count aborts without an expiry.
    bus_wr(BASE + 16'd6, 8'h00);
    bus_wr(BASE + 16'd2, 8'h03);
    bus_wr(BASE + 16'd0, 8'h04);
    bus_wr(BASE + 16'd3, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("midreset_irq_c%0d", i), 8'(irq_n), 8'h01);
    end
    rd_chk(BASE + 16'd4, 8'h00, "midreset_count_lo");
    rd_chk(BASE + 16'd0, 8'h00, "midreset_ctrl");
    rd_chk(BASE + 16'd1, 8'h00, "midreset_status");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_timer_periph.md
# bus_timer_periph

Memory-mapped 16-bit interval timer that sits on the CPU address/data bus as a responder beside `mem`. It decodes an 8-byte window, services CPU reads and writes with the same `addr`/`we`/`din`/`dout` protocol as `mem`, and raises `irq_n` toward the CPU's interrupt input when the count expires. It gives the test system a real interrupt source for IRQ-path bring-up.

## Interface
- `BASE_ADDR`, default 16'h4000: base of the 8-byte register window; must be 8-aligned.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  in  `ADDR_WIDTH` (16)  CPU address.
- `we`  in  1  write strobe (CPU `!R_W_n`).
- `din`  in  `REG_WIDTH` (8)  write data from CPU.
- `dout`  out  `REG_WIDTH`  registered read data.
- `hit`  out  1  registered: the previous cycle's address fell in the window. The top-level data mux selects `dout` over `mem` when `hit` is high.
- `irq_n`  out  1  active-low interrupt request, level.

## Operation
- Window: `sel = (addr[15:3] == BASE_ADDR[15:3])`. The offset is `addr[2:0]`.
- Registers:
  - 0 CTRL, R/W: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (IRQ enable), bits 7:3 read 0.
  - 1 STATUS: bit0 FLAG (sticky expiry), bit1 RUN (mirror of EN). Writing 1 to bit0 clears FLAG. Writes to other bits are ignored.
  - 2 RELOAD_LO, R/W.
  - 3 RELOAD_HI, R/W. A write also loads COUNT from {din, RELOAD_LO}, sets EN, and clears the prescaler.
  - 4 COUNT_LO, RO. A read also snapshots COUNT[15:8] into the HI latch.
  - 5 COUNT_HI, RO: returns the HI latch, not the live count.
  - 6 PRESCALE, R/W: a tick occurs every PRESCALE+1 clocks.
  - 7: reads 0, writes ignored.
- Prescaler: 8-bit counter PC. When EN=1: if PC==PRESCALE then PC←0 and tick=1, else PC←PC+1. When EN=0, PC holds at 0. An EN 0→1 transition via CTRL also clears PC.
- Counter, on a tick:
  - If COUNT≠0: COUNT←COUNT−1.
  - If COUNT==0 (expire): FLAG←1. If AUTO, COUNT←RELOAD. Otherwise COUNT holds at 0 and EN←0.
- Period with AUTO set: (RELOAD+1)·(PRESCALE+1) clocks.
- `irq_n = ~(FLAG & IE)`, driven from registers only.
- Simultaneous events:
  - Expiry in the same cycle as a STATUS clear-write: FLAG ends at 1 (set wins).
  - A RELOAD_HI write in the same cycle as a tick: the write wins, COUNT takes the new value, PC←0.
  - A CTRL write with EN=0 in the same cycle as an expiry: EN ends at 0, and FLAG still sets.
- Non-hit cycles: `dout`←0.
- Reset: all registers 0 (CTRL, STATUS, RELOAD, COUNT, PRESCALE, HI latch, PC). `dout`=0, `hit`=0, `irq_n`=1. A reset asserted mid-count aborts the count immediately; no expiry is reported.

## Timing
- Write: takes effect at the rising `clk` edge where `sel & we`.
- Read:
  - `addr` is sampled at edge N; `dout`/`hit` are valid after edge N and held until edge N+1. Latency is one cycle.
  - Read side effects (HI snapshot) occur at edge N.
  - A read on the same edge as a write to the same register returns the pre-write value.
- Expiry: FLAG is set at the edge of the expiring tick; `irq_n` falls at that same edge.
- Clearing STATUS: `irq_n` rises at the write edge.
- Timer start: after a RELOAD_HI write at edge W with PRESCALE=p, the first decrement is at edge W+p+1.

## Structure
- Shared package holds:
  - register offset localparams (`TMR_CTRL`…`TMR_PRESCALE`);
  - CTRL/STATUS bit indices;
  - width macros reused from the existing package (`ADDR_WIDTH`, `REG_WIDTH`).
- One sub-module, `timer_prescaler`: ports `clk`, `reset`, `en`, `clr`, `div[7:0]`, `tick`. The bus decode, register file and counter stay in the top-level module.

## Test plan
- Reset: hold `reset` for 3 cycles while writing CTRL=0x07 → all reads return 0x00, `irq_n`=1, `hit`=0.
- One-shot:
  - Stimulus: PRESCALE=0, RELOAD_LO=0x03, RELOAD_HI=0x00, IE=1, AUTO=0.
  - Response: `irq_n` falls exactly 4 clocks after the RELOAD_HI edge; STATUS reads 0x01 (RUN=0); COUNT stays 0x0000.
  - Then write STATUS=0x01 → `irq_n`=1.
- Auto-reload with prescale:
  - Stimulus: PRESCALE=2, RELOAD=0x0001, AUTO=1, IE=1.
  - Response: FLAG sets every 6 clocks. Clear it after each expiry and check 3 periods.
- Latched read: with RELOAD=0x0100, PRESCALE=0 running, read COUNT_LO when COUNT=0x0100 → returns 0x00. After 5 more clocks read COUNT_HI → returns 0x01, not 0x00.
- Collisions:
  - STATUS clear-write on the expiry edge → FLAG stays 1.
  - RELOAD_HI=0x00 write (RELOAD_LO=0x05) on a tick edge → COUNT=0x0005.
- Decode and latency:
  - Write to BASE_ADDR+8 → no register changes.
  - Read BASE_ADDR+7 → `dout`=0x00 with `hit`=1 one cycle later.
  - Read 0x0000 → `hit`=0.
  - Reset asserted mid-count → `irq_n` never falls.
